uart_rx_word_buffer: RTL and testbench

//   Downstream of the UART receiver. Packs received bytes into 32-bit little-endian words.

---
 rtl/uart_rx_word_buffer.sv | 150 +++++++++++++++
 tb/tb_uart_rx_word_buffer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_word_buffer.sv
// Packs UART receiver bytes into 32-bit little-endian words and queues them in a
// first-word-fall-through FIFO; stalled partial words are dropped after GAP_CLKS idle clocks.
module uart_rx_word_buffer #(
    parameter int DEPTH_LOG2 = 4,
    parameter int GAP_CLKS   = 80000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            i_Rx_Byte,
    input  logic                  i_Rx_DV,
    input  logic                  i_rd_en,
    input  logic                  i_clr_overflow,
    output logic [31:0]           o_rd_data,
    output logic                  o_empty,
    output logic                  o_full,
    output logic [DEPTH_LOG2:0]   o_count,
    output logic [1:0]            o_byte_idx,
    output logic                  o_overflow
);

    localparam int DEPTH    = 1 << DEPTH_LOG2;
    localparam int GAP_W    = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;
    localparam int GAP_LAST = GAP_CLKS - 1;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = DEPTH[DEPTH_LOG2:0];
    localparam logic [GAP_W-1:0]    GAP_END   = GAP_LAST[GAP_W-1:0];

    typedef enum logic [1:0] {
        BYTE0 = 2'd0,
        BYTE1 = 2'd1,
        BYTE2 = 2'd2,
        BYTE3 = 2'd3
    } state_e;

    state_e                  state_q, state_d;
    logic [GAP_W-1:0]        gap_q, gap_d;
    logic                    timeout;
    logic                    push;
    logic [23:0]             word_q;
    logic [31:0]             push_word;

    logic [31:0]             mem [DEPTH];
    logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]     count_q, count_d;
    logic                    ovf_q, ovf_d;
    logic                    pop, accept, drop;

    // An arriving byte always beats a timeout in the same cycle.
    assign timeout = (state_q != BYTE0) && !i_Rx_DV && (gap_q == GAP_END);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= BYTE0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (i_Rx_DV) begin
            unique case (state_q)
                BYTE0:   state_d = BYTE1;
                BYTE1:   state_d = BYTE2;
                BYTE2:   state_d = BYTE3;
                default: state_d = BYTE0;
            endcase
        end else if (timeout) begin
            state_d = BYTE0;
        end
    end

    always_comb begin
        push       = i_Rx_DV && (state_q == BYTE3);
        o_byte_idx = state_q;
    end

    always_comb begin
        gap_d = gap_q + GAP_W'(1);
        if (i_Rx_DV || (state_q == BYTE0) || timeout) begin
            gap_d = '0;
        end
    end

    // Lower three bytes are staged; the fourth goes straight into the FIFO.
    always_ff @(posedge clk) begin
        if (i_Rx_DV) begin
            unique case (state_q)
                BYTE0:   word_q[7:0]   <= i_Rx_Byte;
                BYTE1:   word_q[15:8]  <= i_Rx_Byte;
                BYTE2:   word_q[23:16] <= i_Rx_Byte;
                default: ;
            endcase
        end
    end

    assign push_word = {i_Rx_Byte, word_q};

    assign o_empty = (count_q == '0);
    assign o_full  = (count_q == DEPTH_CNT);
    assign o_count = count_q;
    assign o_overflow = ovf_q;

    // A pop frees the slot the push needs, so a full FIFO still accepts.
    assign pop    = i_rd_en && !o_empty;
    assign accept = push && (!o_full || pop);
    assign drop   = push && o_full && !pop;

    always_comb begin
        wr_ptr_d = accept ? wr_ptr_q + DEPTH_LOG2'(1) : wr_ptr_q;
        rd_ptr_d = pop    ? rd_ptr_q + DEPTH_LOG2'(1) : rd_ptr_q;
        count_d  = count_q;
        unique case ({accept, pop})
            2'b10:   count_d = count_q + (DEPTH_LOG2 + 1)'(1);
            2'b01:   count_d = count_q - (DEPTH_LOG2 + 1)'(1);
            default: count_d = count_q;
        endcase
        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (i_clr_overflow) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr_q] <= push_word;
        end
    end

    assign o_rd_data = o_empty ? 32'h0 : mem[rd_ptr_q];

endmodule

// File: tb/tb_uart_rx_word_buffer.sv
// Directed bench for uart_rx_word_buffer: packing, FIFO fill/drain, overflow, gap timeout, async reset.
module tb_uart_rx_word_buffer;

    localparam int DEPTH_LOG2 = 4;
    localparam int GAP_CLKS   = 16;

    logic                clk;
    logic                reset;
    logic [7:0]          i_Rx_Byte;
    logic                i_Rx_DV;
    logic                i_rd_en;
    logic                i_clr_overflow;
    logic [31:0]         o_rd_data;
    logic                o_empty;
    logic                o_full;
    logic [DEPTH_LOG2:0] o_count;
    logic [1:0]          o_byte_idx;
    logic                o_overflow;

    int n_checks = 0;
    int n_pass   = 0;

    uart_rx_word_buffer #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .GAP_CLKS   (GAP_CLKS)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .i_Rx_Byte      (i_Rx_Byte),
        .i_Rx_DV        (i_Rx_DV),
        .i_rd_en        (i_rd_en),
        .i_clr_overflow (i_clr_overflow),
        .o_rd_data      (o_rd_data),
        .o_empty        (o_empty),
        .o_full         (o_full),
        .o_count        (o_count),
        .o_byte_idx     (o_byte_idx),
        .o_overflow     (o_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        i_Rx_Byte = b;
        i_Rx_DV   = 1'b1;
        tick();
        i_Rx_DV   = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[7:0]);
        send_byte(w[15:8]);
        send_byte(w[23:16]);
        send_byte(w[31:24]);
    endtask

    task automatic pop_word();
        i_rd_en = 1'b1;
        tick();
        i_rd_en = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_count"},  32'(o_count),    32'd0);
        check({tag, "_empty"},  32'(o_empty),    32'd1);
        check({tag, "_full"},   32'(o_full),     32'd0);
        check({tag, "_rdata"},  o_rd_data,       32'h0);
        check({tag, "_idx"},    32'(o_byte_idx), 32'd0);
        check({tag, "_ovf"},    32'(o_overflow), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset          = 1'b1;
        i_Rx_Byte      = 8'h00;
        i_Rx_DV        = 1'b0;
        i_rd_en        = 1'b0;
        i_clr_overflow = 1'b0;
        #1;
        check_reset_state("rst");
        tick();
        tick();
        reset = 1'b0;

        // Test 1: single word packing
        send_byte(8'h78); check("t1_idx1", 32'(o_byte_idx), 32'd1);
        send_byte(8'h56); check("t1_idx2", 32'(o_byte_idx), 32'd2);
        send_byte(8'h34); check("t1_idx3", 32'(o_byte_idx), 32'd3);
        check("t1_empty_pre", 32'(o_empty), 32'd1);
        send_byte(8'h12); check("t1_idx0", 32'(o_byte_idx), 32'd0);
        check("t1_rdata", o_rd_data, 32'h12345678);
        check("t1_count", 32'(o_count), 32'd1);
        check("t1_empty", 32'(o_empty), 32'd0);
        pop_word();
        check("t1_popped", 32'(o_empty), 32'd1);

        // Test 2: fill to full, then overflow
        for (int i = 0; i < 16; i++) send_word(32'hA000_0000 + 32'(i));
        check("t2_full", 32'(o_full), 32'd1);
        check("t2_count16", 32'(o_count), 32'd16);
        check("t2_ovf0", 32'(o_overflow), 32'd0);
        send_word(32'hBAD0_0017);
        check("t2_ovf1", 32'(o_overflow), 32'd1);
        check("t2_count_hold", 32'(o_count), 32'd16);
        check("t2_head", o_rd_data, 32'hA000_0000);

        // Test 6: overflow set beats clear, then clear alone
        send_byte(8'h18); send_byte(8'h00); send_byte(8'hD0);
        i_clr_overflow = 1'b1;
        send_byte(8'hBA);
        i_clr_overflow = 1'b0;
        check("t6_set_wins", 32'(o_overflow), 32'd1);
        check("t6_count", 32'(o_count), 32'd16);
        i_clr_overflow = 1'b1;
        tick();
        i_clr_overflow = 1'b0;
        check("t6_cleared", 32'(o_overflow), 32'd0);

        // Test 4: push with simultaneous pop while full
        send_byte(8'h04); send_byte(8'hEE); send_byte(8'hFF);
        i_rd_en = 1'b1;
        send_byte(8'hC0);
        i_rd_en = 1'b0;
        check("t4_count", 32'(o_count), 32'd16);
        check("t4_ovf", 32'(o_overflow), 32'd0);
        check("t4_full", 32'(o_full), 32'd1);
        check("t4_head", o_rd_data, 32'hA000_0001);

        for (int i = 1; i < 16; i++) begin
            check($sformatf("t2_pop%0d", i), o_rd_data, 32'hA000_0000 + 32'(i));
            pop_word();
        end
        check("t4_last", o_rd_data, 32'hC0FF_EE04);
        pop_word();
        check("t2_empty", 32'(o_empty), 32'd1);
        check("t2_rdata0", o_rd_data, 32'h0);
        check("t2_count0", 32'(o_count), 32'd0);
        pop_word();
        check("t2_popempty_cnt", 32'(o_count), 32'd0);
        check("t2_popempty_ovf", 32'(o_overflow), 32'd0);

        // Test 3: gap timeout discards partial word
        send_byte(8'h11); send_byte(8'h22);
        repeat (GAP_CLKS - 1) tick();
        check("t3_idx_hold", 32'(o_byte_idx), 32'd2);
        tick();
        check("t3_idx_to", 32'(o_byte_idx), 32'd0);
        check("t3_count", 32'(o_count), 32'd0);
        send_word(32'hDDCC_BBAA);
        check("t3_word", o_rd_data, 32'hDDCC_BBAA);
        check("t3_count1", 32'(o_count), 32'd1);
        pop_word();
        send_byte(8'h33);
        repeat (GAP_CLKS - 1) tick();
        send_byte(8'h44);
        check("t3_byte_wins", 32'(o_byte_idx), 32'd2);
        send_byte(8'h55); send_byte(8'h66);
        check("t3_word2", o_rd_data, 32'h6655_4433);
        pop_word();

        // Test 5: async reset mid-word
        for (int i = 0; i < 5; i++) send_word(32'h5000_0000 + 32'(i));
        send_byte(8'hE1); send_byte(8'hE2);
        check("t5_pre_count", 32'(o_count), 32'd5);
        check("t5_pre_idx", 32'(o_byte_idx), 32'd2);
        #3;
        reset = 1'b1;
        #1;
        check_reset_state("t5");
        #2;
        reset = 1'b0;
        tick();
        send_word(32'h8765_4321);
        check("t5_word", o_rd_data, 32'h8765_4321);
        check("t5_count", 32'(o_count), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
